// File: rtl/motion_cmd_sequencer_if.sv
// Peripheral register bus driven by the motion command sequencer.
interface motion_cmd_sequencer_if;
  logic        per_cs;
  logic [7:0]  per_addr;
  logic        per_rd;
  logic        per_wr;
  logic [15:0] per_d_out;
  logic [15:0] per_d_in;

  modport master (
    output per_cs, per_addr, per_rd, per_wr, per_d_out,
    input  per_d_in
  );

  modport slave (
    input  per_cs, per_addr, per_rd, per_wr, per_d_out,
    output per_d_in
  );
endinterface

// File: rtl/motion_cmd_sequencer.sv
// Motion command queue: buffers 8-word commands from the host, writes each into
// the peripheral registers, starts it via SS and polls SS until done or timeout.
module motion_cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [15:0]            push_data,
  output logic                   push_ready,
  input  logic                   enable,
  input  logic                   err_clr,
  output logic                   busy,
  output logic                   cmd_done,
  output logic                   err,
  output logic [$clog2(DEPTH):0] cmd_count,
  motion_cmd_sequencer_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned MW = AW + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RD, S_CHK, S_DONE, S_ABORT
  } state_t;

  logic [15:0]   r_mem [DEPTH*8];
  logic [AW-1:0] r_wr_slot;
  logic [AW-1:0] r_rd_slot;
  logic [2:0]    r_word_idx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_occ;
  logic          r_push_ready;

  state_t        r_state;
  logic [2:0]    r_ld_idx;
  logic [15:0]   r_gap;
  logic [15:0]   r_tmo;
  logic          r_cs;
  logic          r_rd;
  logic          r_wr;
  logic [7:0]    r_addr;
  logic [15:0]   r_dout;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_push_acc;
  logic          w_push_last;
  logic          w_start;
  logic          w_timeout;
  logic          w_release;
  logic [2:0]    w_ld_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_occ_nxt;
  logic [MW-1:0] w_wr_ptr;

  // Queue bookkeeping and FSM decisions shared by both sequential blocks.
  always_comb begin
    w_push_acc  = push && r_push_ready;
    w_push_last = w_push_acc && (r_word_idx == 3'd7);
    // A command completing this cycle can start immediately when idle.
    w_start     = ((r_state == S_IDLE) || (r_state == S_DONE)) && enable &&
                  ((r_cnt != '0) || w_push_last);
    w_timeout   = ((r_state == S_WAIT) || (r_state == S_RD) || (r_state == S_CHK)) &&
                  (r_tmo == 16'(TIMEOUT));
    w_release   = w_timeout || ((r_state == S_CHK) && !bus.per_d_in[0]);
    w_ld_nxt    = r_ld_idx + 3'd1;
    // cmd_count excludes the executing command; occupancy includes it.
    w_cnt_nxt   = r_cnt + CW'(w_push_last) - CW'(w_start);
    w_occ_nxt   = r_occ + CW'(w_push_last) - CW'(w_release);
    w_wr_ptr    = {r_wr_slot, r_word_idx};
  end

  // Command word storage, one slot of 8 words per command.
  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[w_wr_ptr] <= push_data;
  end

  // Slot pointers, word index and queue counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_slot    <= '0;
      r_rd_slot    <= '0;
      r_word_idx   <= '0;
      r_cnt        <= '0;
      r_occ        <= '0;
      r_push_ready <= 1'b1;
    end else begin
      if (w_push_acc) begin
        r_word_idx <= r_word_idx + 3'd1;
        if (w_push_last) r_wr_slot <= r_wr_slot + AW'(1);
      end
      if (w_release) r_rd_slot <= r_rd_slot + AW'(1);
      r_cnt        <= w_cnt_nxt;
      r_occ        <= w_occ_nxt;
      r_push_ready <= (w_occ_nxt < CW'(DEPTH));
    end
  end

  // Execution FSM with registered bus and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ld_idx <= '0;
      r_gap    <= '0;
      r_tmo    <= '0;
      r_cs     <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cs   <= 1'b0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_dout <= '0;
      r_done <= 1'b0;
      if (err_clr) r_err <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state  <= S_LOAD;
            r_busy   <= 1'b1;
            r_ld_idx <= '0;
            r_cs     <= 1'b1;
            r_wr     <= 1'b1;
            r_addr   <= 8'h02;
            r_dout   <= r_mem[{r_rd_slot, 3'd0}];
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_cs <= 1'b1;
          r_wr <= 1'b1;
          if (r_ld_idx == 3'd7) begin
            r_state <= S_START;
            r_addr  <= 8'h00;
            r_dout  <= 16'h0001;
          end else begin
            r_ld_idx <= w_ld_nxt;
            r_addr   <= 8'h02 + {4'b0000, w_ld_nxt, 1'b0};
            r_dout   <= r_mem[{r_rd_slot, w_ld_nxt}];
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_tmo   <= '0;
          r_gap   <= '0;
        end
        S_WAIT, S_RD, S_CHK: begin
          if (r_tmo != 16'hFFFF) r_tmo <= r_tmo + 16'd1;
          if (w_timeout) begin
            r_state <= S_ABORT;
            r_cs    <= 1'b1;
            r_wr    <= 1'b1;
            r_dout  <= 16'h0002;
            r_err   <= 1'b1;
          end else if (r_state == S_WAIT) begin
            if (r_gap == 16'(POLL_GAP - 1)) begin
              r_state <= S_RD;
              r_cs    <= 1'b1;
              r_rd    <= 1'b1;
            end else begin
              r_gap <= r_gap + 16'd1;
            end
          end else if (r_state == S_RD) begin
            r_state <= S_CHK;
          end else if (!bus.per_d_in[0]) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
            r_gap   <= '0;
          end
        end
        S_ABORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign push_ready    = r_push_ready;
  assign busy          = r_busy;
  assign cmd_done      = r_done;
  assign err           = r_err;
  assign cmd_count     = r_cnt;
  assign bus.per_cs    = r_cs;
  assign bus.per_addr  = r_addr;
  assign bus.per_rd    = r_rd;
  assign bus.per_wr    = r_wr;
  assign bus.per_d_out = r_dout;

endmodule
